// File: rtl/pc_ctrl_pkg.sv
// Shared types and default sizes for the PC fetch controller.
package pc_ctrl_pkg;

  localparam int unsigned DefXlen    = 64;
  localparam logic [63:0] DefPcLimit = 64'h200;
  localparam int unsigned DefRaW     = 5;
  localparam int unsigned DefCntW    = 16;

  typedef enum logic [1:0] {
    StRun,
    StMemWait,
    StRedirect,
    StHalt
  } state_e;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Pipeline-facing signals of the fetch controller.
// The master side is the controller; the slave side is the pipeline.
interface pc_fetch_ctrl_if
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned XLEN  = DefXlen,
  parameter int unsigned RA_W  = DefRaW,
  parameter int unsigned CNT_W = DefCntW
) ();

  // Pipeline status into the controller
  logic [XLEN-1:0]  pc_current;
  logic [RA_W-1:0]  id_rs1;
  logic [RA_W-1:0]  id_rs2;
  logic [RA_W-1:0]  ex_rd;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic [XLEN-1:0]  ex_branch_target;
  logic             mem_busy;

  // Controls out to the PC register and stage latches
  logic             PC_write;
  logic             PCSrc;
  logic [XLEN-1:0]  pc_branch;
  logic             IF_ID_write;
  logic             IF_ID_flush;
  logic             ID_EX_bubble;
  logic             halted;
  logic [CNT_W-1:0] stall_count;

  modport master (
    input  pc_current, id_rs1, id_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, ex_branch_target, mem_busy,
    output PC_write, PCSrc, pc_branch, IF_ID_write, IF_ID_flush,
           ID_EX_bubble, halted, stall_count
  );

  modport slave (
    output pc_current, id_rs1, id_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, ex_branch_target, mem_busy,
    input  PC_write, PCSrc, pc_branch, IF_ID_write, IF_ID_flush,
           ID_EX_bubble, halted, stall_count
  );

endinterface

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination feeds a source of the instruction in ID.
// x0 is never a real dependency.
module load_use_detect #(
  parameter int unsigned RA_W = 5
) (
  input  logic            ex_mem_read,
  input  logic [RA_W-1:0] ex_rd,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  output logic            load_use
);

  // Pure compare, no state
  always_comb begin
    load_use = ex_mem_read && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencing controller: arbitrates memory freeze, branch redirect,
// load-use stall and end-of-program, driving the PC register and IF/ID, ID/EX
// latch controls. End of program parks in a sticky HALT until reset.
module pc_fetch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN     = DefXlen,
  parameter logic [XLEN-1:0] PC_LIMIT = XLEN'(DefPcLimit),
  parameter int unsigned     RA_W     = DefRaW,
  parameter int unsigned     CNT_W    = DefCntW
) (
  input  logic             clk,
  input  logic             rst,
  pc_fetch_ctrl_if.master  bus
);

  // Address of the last instruction slot in program space
  localparam logic [XLEN-1:0] LastFetch = PC_LIMIT - XLEN'(4);

  state_e           state_q, state_d;
  logic [XLEN-1:0]  target_q;
  logic [CNT_W-1:0] cnt_q;

  logic load_use;
  logic at_limit;
  logic capture;
  logic pc_write;
  logic pc_src;
  logic if_id_write;
  logic if_id_flush;
  logic id_ex_bubble;
  logic halted;

  load_use_detect #(
    .RA_W (RA_W)
  ) u_load_use_detect (
    .ex_mem_read (bus.ex_mem_read),
    .ex_rd       (bus.ex_rd),
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .load_use    (load_use)
  );

  assign at_limit = (bus.pc_current >= LastFetch);

  // Mealy outputs and next state; reset forces the safe drain pattern immediately
  always_comb begin
    state_d      = state_q;
    capture      = 1'b0;
    pc_write     = 1'b1;
    pc_src       = 1'b0;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    halted       = 1'b0;
    if (!rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      case (state_q)
        StRun: begin
          if (bus.mem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            state_d     = StMemWait;
          end else if (bus.ex_branch_taken) begin
            // ID holds a wrong-path instruction, so any load-use hit is moot
            capture      = 1'b1;
            pc_write     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_d      = StRedirect;
          end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (at_limit) begin
            pc_write = 1'b0;
            state_d  = StHalt;
          end
        end
        StMemWait: begin
          // Release cycle uses plain RUN outputs; events are seen next cycle
          if (bus.mem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
          end else begin
            state_d = StRun;
          end
        end
        StRedirect: begin
          pc_src       = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          if (bus.mem_busy) begin
            pc_write = 1'b0;
          end else begin
            state_d = StRun;
          end
        end
        StHalt: begin
          // Older instructions keep draining; nothing new enters IF/ID
          pc_write    = 1'b0;
          if_id_flush = 1'b1;
          halted      = 1'b1;
        end
        default: state_d = StRun;
      endcase
    end
  end

  // State, redirect target and saturating stall counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StRun;
      target_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        target_q <= bus.ex_branch_target;
      end
      if (!pc_write && (state_q != StHalt) && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.PC_write     = pc_write;
  assign bus.PCSrc        = pc_src;
  assign bus.pc_branch    = target_q;
  assign bus.IF_ID_write  = if_id_write;
  assign bus.IF_ID_flush  = if_id_flush;
  assign bus.ID_EX_bubble = id_ex_bubble;
  assign bus.halted       = halted;
  assign bus.stall_count  = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: each row drives one cycle of inputs and
// pushes the expected outputs; the outputs are sampled mid-cycle and compared.
module tb_pc_fetch_ctrl;
  import pc_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pc_fetch_ctrl_if bus ();

  pc_fetch_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        pc_write;
    logic        pc_src;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        halted;
    logic [63:0] pc_branch;
    logic [15:0] stall_count;
  } obs_t;

  typedef struct packed {
    logic        rstn;
    logic        mem_busy;
    logic        br;
    logic [63:0] tgt;
    logic        mr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] pc;
    logic [5:0]  flags;  // {PC_write, PCSrc, IF_ID_write, IF_ID_flush, ID_EX_bubble, halted}
    logic [63:0] etgt;
  } row_t;

  localparam logic [5:0] FDefault  = 6'b101000;
  localparam logic [5:0] FReset    = 6'b000110;
  localparam logic [5:0] FLoadUse  = 6'b000010;
  localparam logic [5:0] FFreeze   = 6'b000000;
  localparam logic [5:0] FBranch   = 6'b001110;
  localparam logic [5:0] FRedirect = 6'b111110;
  localparam logic [5:0] FRedHold  = 6'b011110;
  localparam logic [5:0] FLimit    = 6'b001000;
  localparam logic [5:0] FHalt     = 6'b001101;

  obs_t        sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] exp_cnt = 16'd0;

  function automatic row_t mk(logic rstn, logic mb, logic br, logic [63:0] tgt, logic mr,
                              logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                              logic [63:0] pc, logic [5:0] f, logic [63:0] etgt);
    row_t r;
    r.rstn = rstn; r.mem_busy = mb; r.br = br; r.tgt = tgt; r.mr = mr;
    r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.pc = pc; r.flags = f; r.etgt = etgt;
    return r;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.pc_write     = bus.PC_write;
    o.pc_src       = bus.PCSrc;
    o.if_id_write  = bus.IF_ID_write;
    o.if_id_flush  = bus.IF_ID_flush;
    o.id_ex_bubble = bus.ID_EX_bubble;
    o.halted       = bus.halted;
    o.pc_branch    = bus.pc_branch;
    o.stall_count  = bus.stall_count;
    return o;
  endfunction

  // Drive one cycle of stimulus and push the expected outputs; the stall counter
  // model counts PC_write=0 cycles outside HALT and reset, saturating at 16'hFFFF.
  task automatic apply(input row_t r);
    obs_t e;
    rst                  = r.rstn;
    bus.mem_busy         = r.mem_busy;
    bus.ex_branch_taken  = r.br;
    bus.ex_branch_target = r.tgt;
    bus.ex_mem_read      = r.mr;
    bus.ex_rd            = r.rd;
    bus.id_rs1           = r.rs1;
    bus.id_rs2           = r.rs2;
    bus.pc_current       = r.pc;
    if (!r.rstn) exp_cnt = 16'd0;
    {e.pc_write, e.pc_src, e.if_id_write, e.if_id_flush, e.id_ex_bubble, e.halted} = r.flags;
    e.pc_branch   = r.etgt;
    e.stall_count = exp_cnt;
    sb.push_back(e);
    if (r.rstn && !e.pc_write && !e.halted && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic test_reset();
    row_t rows[$];
    obs_t got, e;
    for (int i = 0; i < 2; i++) rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 'h10, FReset, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      #1;
      got = sample();
      e = sb.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %h expected %h", i, got, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_idle();
    row_t rows[$];
    obs_t got, e;
    for (int i = 0; i < 3; i++) rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 'h10, FDefault, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      #1;
      got = sample();
      e = sb.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL idle[%0d]: got %h expected %h", i, got, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_use();
    row_t rows[$];
    obs_t got, e;
    rows.push_back(mk(1, 0, 0, 0, 1, 5, 3, 5, 'h10, FLoadUse, 0));
    rows.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 'h10, FDefault, 0));   // x0 never stalls
    rows.push_back(mk(1, 0, 0, 0, 1, 7, 7, 2, 'h10, FLoadUse, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 7, 7, 7, 'h10, FDefault, 0));   // not a load
    rows.push_back(mk(1, 0, 0, 0, 1, 9, 8, 10, 'h10, FDefault, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      #1;
      got = sample();
      e = sb.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL load_use[%0d]: got %h expected %h", i, got, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    row_t rows[$];
    obs_t got, e;
    rows.push_back(mk(1, 0, 1, 'h40, 1, 5, 5, 0, 'h14, FBranch, 0));     // load-use ignored
    rows.push_back(mk(1, 0, 0, 'h99, 1, 5, 5, 0, 'h14, FRedirect, 'h40));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 'h40, FDefault, 'h40));
    foreach (rows[i]) begin
      apply(rows[i]);
      #1;
      got = sample();
      e = sb.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL branch[%0d]: got %h expected %h", i, got, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_redirect();
    row_t rows[$];
    obs_t got, e;
    rows.push_back(mk(1, 0, 1, 'h123, 0, 0, 0, 0, 'h44, FBranch, 'h40));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 'h44, FReset, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 'h10, FDefault, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      #1;
      got = sample();
      e = sb.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset_mid_redirect[%0d]: got %h expected %h", i, got, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mem_freeze();
    row_t rows[$];
    obs_t got, e;
    for (int i = 0; i < 3; i++) rows.push_back(mk(1, 1, 1, 'h40, 0, 0, 0, 0, 'h20, FFreeze, 0));
    rows.push_back(mk(1, 0, 1, 'h40, 0, 0, 0, 0, 'h20, FDefault, 0));
    rows.push_back(mk(1, 0, 1, 'h40, 0, 0, 0, 0, 'h24, FBranch, 0));
    rows.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 'h24, FRedHold, 'h40));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 'h24, FRedirect, 'h40));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 'h40, FDefault, 'h40));
    foreach (rows[i]) begin
      apply(rows[i]);
      #1;
      got = sample();
      e = sb.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL mem_freeze[%0d]: got %h expected %h", i, got, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_halt();
    row_t rows[$];
    obs_t got, e;
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 'h1F8, FDefault, 'h40));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 'h1FC, FLimit, 'h40));
    for (int i = 0; i < 12; i++) begin
      rows.push_back(mk(1, 1'($urandom_range(1)), 1'($urandom_range(1)), 64'($urandom),
                        1'($urandom_range(1)), 5'($urandom_range(31)), 5'($urandom_range(31)),
                        5'($urandom_range(31)), 64'($urandom_range(255)), FHalt, 'h40));
    end
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 'h200, FReset, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 'h10, FDefault, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      #1;
      got = sample();
      e = sb.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL halt[%0d]: got %h expected %h", i, got, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_saturate();
    obs_t got, e;
    int   total;
    total = 65536 + 2;
    for (int i = 0; i <= total; i++) begin
      if (i < total) apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 'h10, FFreeze, 0));
      else           apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 'h10, FDefault, 0));
      #1;
      got = sample();
      e = sb.pop_front();
      if (i < 3 || i > total - 4) begin
        n_cmp++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL saturate[%0d]: got %h expected %h", i, got, e);
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    bus.mem_busy         = 1'b0;
    bus.ex_branch_taken  = 1'b0;
    bus.ex_branch_target = '0;
    bus.ex_mem_read      = 1'b0;
    bus.ex_rd            = '0;
    bus.id_rs1           = '0;
    bus.id_rs2           = '0;
    bus.pc_current       = '0;
    @(negedge clk);
    test_reset();
    test_idle();
    test_load_use();
    test_branch();
    test_reset_mid_redirect();
    test_mem_freeze();
    test_halt();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
